// File: rtl/mmio_input_reader_pkg.sv
// Shared address map and widths for the memory-mapped board I/O peripherals.
// The display address lives here too so both peripherals decode from one map.
package mmio_input_reader_pkg;

  localparam logic [31:0] ADDR_DISP = 32'h0000_0148;
  localparam logic [31:0] ADDR_SW   = 32'h0000_0150;
  localparam logic [31:0] ADDR_BTN  = 32'h0000_0154;
  localparam logic [31:0] ADDR_EVT  = 32'h0000_0158;

  localparam int SW_W  = 16;
  localparam int BTN_W = 4;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SW,
    SEL_BTN,
    SEL_EVT
  } regSel_t;

  // Full 32-bit compare so no register aliases anywhere else in the map.
  function automatic regSel_t decodeAddr(input logic [31:0] addr);
    regSel_t sel;
    sel = SEL_NONE;
    if (addr == ADDR_SW)  sel = SEL_SW;
    if (addr == ADDR_BTN) sel = SEL_BTN;
    if (addr == ADDR_EVT) sel = SEL_EVT;
    return sel;
  endfunction

endpackage

// File: rtl/mmio_input_reader_debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter, debounced level
// and a registered one-cycle pulse when the debounced level rises.
module mmio_input_reader_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // The level only moves after DEBOUNCE_CYCLES consecutive differing samples;
  // a single agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      if (r_sync != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync;
          r_rise  <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/mmio_input_reader.sv
// Read-side board peripheral: debounced switches and buttons, sticky button
// press flags with write-1-to-clear, and a registered read port.
module mmio_input_reader
  import mmio_input_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        RE,
  input  logic        WE,
  input  logic [31:0] datain,
  input  logic [15:0] sw,
  input  logic [3:0]  btn,
  output logic [31:0] dataread,
  output logic        event_pending
);

  localparam int IN_W = SW_W + BTN_W;

  logic [IN_W-1:0]  w_raw;
  logic [IN_W-1:0]  w_level;
  logic [IN_W-1:0]  w_rise;
  logic [SW_W-1:0]  w_swDb;
  logic [BTN_W-1:0] w_btnDb;
  logic [BTN_W-1:0] w_btnRise;
  logic [BTN_W-1:0] w_clr;
  logic [31:0]      w_readData;
  logic             w_unused;

  logic [BTN_W-1:0] r_evt;
  logic             r_pend;
  logic [31:0]      r_dataread;

  assign w_raw = {btn, sw};

  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_db
      mmio_input_reader_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce_bit (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (w_raw[gi]),
        .o_level(w_level[gi]),
        .o_rise (w_rise[gi])
      );
    end
  endgenerate

  assign w_swDb    = w_level[SW_W-1:0];
  assign w_btnDb   = w_level[IN_W-1:SW_W];
  assign w_btnRise = w_rise[IN_W-1:SW_W];
  // Switch rise pulses and the upper write-data bits have no consumer.
  assign w_unused  = ^{w_rise[SW_W-1:0], datain[31:BTN_W]};

  assign w_clr = (WE && (address == ADDR_EVT)) ? datain[BTN_W-1:0] : '0;

  always_comb begin
    w_readData = '0;
    case (decodeAddr(address))
      SEL_SW:  w_readData = {{(32-SW_W){1'b0}}, w_swDb};
      SEL_BTN: w_readData = {{(32-BTN_W){1'b0}}, w_btnDb};
      SEL_EVT: w_readData = {{(32-BTN_W){1'b0}}, r_evt};
      default: w_readData = '0;
    endcase
  end

  // Ordering the set after the clear makes a same-cycle press win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt      <= '0;
      r_pend     <= 1'b0;
      r_dataread <= '0;
    end else begin
      r_evt  <= (r_evt & ~w_clr) | w_btnRise;
      r_pend <= |r_evt;
      if (RE) r_dataread <= w_readData;
    end
  end

  assign dataread      = r_dataread;
  assign event_pending = r_pend;

endmodule

// File: tb/tb_mmio_input_reader.sv
// Directed self-checking bench for mmio_input_reader with a short debounce
// window so every latency can be counted by hand.
module tb_mmio_input_reader;
  import mmio_input_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic        RE;
  logic        WE;
  logic [31:0] datain;
  logic [15:0] sw;
  logic [3:0]  btn;
  logic [31:0] dataread;
  logic        event_pending;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] expData;
    logic        expPend;
    string       name;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  mmio_input_reader #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .RE           (RE),
    .WE           (WE),
    .datain       (datain),
    .sw           (sw),
    .btn          (btn),
    .dataread     (dataread),
    .event_pending(event_pending)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One bus cycle: strobes are held across exactly one rising edge.
  task automatic applyStimulus(input logic re, input logic we,
                               input logic [31:0] addr, input logic [31:0] din);
    RE      = re;
    WE      = we;
    address = addr;
    datain  = din;
    tick(1);
    RE     = 1'b0;
    WE     = 1'b0;
    datain = '0;
  endtask

  task automatic readCheck(input logic [31:0] addr, input logic [31:0] exp,
                           input string name);
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    checkOutput(name, dataread, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    address = '0;
    RE      = 1'b0;
    WE      = 1'b0;
    datain  = '0;
    sw      = '0;
    btn     = '0;

    // Reset state
    tick(2);
    checkOutput("reset_dataread", dataread, 32'h0);
    checkOutput("reset_pending", {31'b0, event_pending}, 32'h0);
    #2 rst_n = 1'b1;
    tick(1);
    readCheck(ADDR_SW,  32'h0, "rst_read_sw");
    readCheck(ADDR_BTN, 32'h0, "rst_read_btn");
    readCheck(ADDR_EVT, 32'h0, "rst_read_evt");
    readCheck(32'h0,    32'h0, "rst_read_zero");
    checkOutput("rst_pending_idle", {31'b0, event_pending}, 32'h0);

    // Switch debounce: visible to a read sampled on the 7th edge, not the 6th
    sw = 16'hA5C3;
    tick(5);
    readCheck(ADDR_SW, 32'h0, "sw_early_read");
    readCheck(ADDR_SW, 32'h0000_A5C3, "sw_settled_read");

    // A 3-cycle glitch is one sample short of the window
    btn = 4'b0100;
    tick(3);
    btn = 4'b0000;
    tick(10);
    readCheck(ADDR_BTN, 32'h0, "glitch_btn");
    readCheck(ADDR_EVT, 32'h0, "glitch_evt");
    checkOutput("glitch_pending", {31'b0, event_pending}, 32'h0);

    btn = 4'b0100;
    tick(10);
    readCheck(ADDR_BTN, 32'h4, "hold_btn");
    readCheck(ADDR_EVT, 32'h4, "hold_evt");
    checkOutput("hold_pending", {31'b0, event_pending}, 32'h1);

    btn = 4'b0110;
    tick(10);
    readCheck(ADDR_EVT, 32'h6, "two_evt");

    // Register-access vectors, starting from evt=0110 with both buttons held
    vecs[0] = '{1'b1, 1'b0, ADDR_EVT,     32'h0,         32'h6,         1'b1, "v_read_evt"};
    vecs[1] = '{1'b0, 1'b1, ADDR_SW,      32'hFFFF_FFFF, 32'h6,         1'b1, "v_we_sw_ignored"};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_015C, 32'h0000_000F, 32'h6,        1'b1, "v_we_unmapped"};
    vecs[3] = '{1'b1, 1'b0, 32'h1000_0158, 32'h0,        32'h0,         1'b1, "v_no_alias"};
    vecs[4] = '{1'b0, 1'b1, ADDR_EVT,     32'h2,         32'h0,         1'b1, "v_clear_bit1"};
    vecs[5] = '{1'b1, 1'b0, ADDR_EVT,     32'h0,         32'h4,         1'b1, "v_after_clear1"};
    vecs[6] = '{1'b1, 1'b1, ADDR_EVT,     32'hFFFF_FFFF, 32'h4,         1'b1, "v_rw_same_cycle"};
    vecs[7] = '{1'b1, 1'b0, ADDR_EVT,     32'h0,         32'h0,         1'b0, "v_after_clear_all"};
    vecs[8] = '{1'b1, 1'b0, ADDR_BTN,     32'h0,         32'h6,         1'b0, "v_read_btn"};
    vecs[9] = '{1'b1, 1'b0, ADDR_SW,      32'h0,         32'h0000_A5C3, 1'b0, "v_read_sw"};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].din);
      checkOutput({vecs[i].name, "_data"}, dataread, vecs[i].expData);
      checkOutput({vecs[i].name, "_pend"}, {31'b0, event_pending}, {31'b0, vecs[i].expPend});
    end

    // Release never sets a flag
    btn = 4'b0000;
    tick(8);
    readCheck(ADDR_EVT, 32'h0, "release_evt");

    // Flag sets on the 7th edge after the pin; a clear on that same edge loses
    btn = 4'b0001;
    tick(6);
    applyStimulus(1'b0, 1'b1, ADDR_EVT, 32'h1);
    readCheck(ADDR_EVT, 32'h1, "set_beats_clear");
    checkOutput("set_beats_clear_pend", {31'b0, event_pending}, 32'h1);
    applyStimulus(1'b0, 1'b1, ADDR_EVT, 32'h1);
    readCheck(ADDR_EVT, 32'h0, "plain_clear");

    // Asynchronous reset in mid-debounce
    btn = 4'b1000;
    tick(8);
    readCheck(ADDR_EVT, 32'h8, "pre_reset_evt");
    checkOutput("pre_reset_pend", {31'b0, event_pending}, 32'h1);
    sw = 16'h1234;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_dataread", dataread, 32'h0);
    checkOutput("async_rst_pend", {31'b0, event_pending}, 32'h0);
    #2 rst_n = 1'b1;
    tick(5);
    readCheck(ADDR_SW,  32'h0,         "post_rst_sw_early");
    readCheck(ADDR_SW,  32'h0000_1234, "post_rst_sw_settled");
    readCheck(ADDR_BTN, 32'h8,         "post_rst_btn");
    readCheck(ADDR_EVT, 32'h8,         "post_rst_evt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_input_reader.md
Name: mmio_input_reader

Overview:
- Memory-mapped input peripheral: the read-side counterpart of the write-only 7-segment display register.
- Samples 16 board switches and 4 push-buttons, then synchronizes and debounces them.
- Latches button press events, and returns switch state, button state and press flags to the processor on a registered read port.
- Sits on the same processor data bus (address/WE/data) as the display peripheral.

Parameters:
DEBOUNCE_CYCLES, 10000, consecutive clk cycles an input must differ from its debounced value before the debounced value updates (min 1)
ADDR_SW, 32'h0150, switch state register (read-only)
ADDR_BTN, 32'h0154, debounced button level register (read-only)
ADDR_EVT, 32'h0158, button press-event flags (read; write-1-to-clear)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
address  input  32  processor byte address
RE  input  1  read enable, one-cycle strobe
WE  input  1  write enable, one-cycle strobe
datain  input  32  processor write data (used only at ADDR_EVT)
sw  input  16  raw slide switches, asynchronous to clk
btn  input  4  raw push-buttons, active-high, asynchronous to clk
dataread  output  32  registered read data
event_pending  output  1  OR of all event flags, registered

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Clear synchronizer flops, debounced values, counters and event flags.
  - dataread=0, event_pending=0.
  - Reset mid-debounce discards the partial count.
- Synchronizer: two flops per input bit; the debouncer sees the value 2 cycles after the pin.
- Debouncer, per bit:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - While synced != debounced, counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, debounced takes synced on the next edge and the counter clears.
  - Any cycle with synced == debounced clears the counter, so a glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Total pin-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles.
- Event flags:
  - evt[i] sets on a debounced btn[i] 0->1 transition. Release does not set it.
  - Write with WE=1, address==ADDR_EVT clears evt[i] for each datain[i]=1. Other datain bits are ignored.
  - Set and clear of the same bit in the same cycle: set wins (the flag stays 1).
  - Flags are sticky; repeated presses while set leave them set.
- Read port:
  - On RE=1, dataread is loaded on the next clk edge (1-cycle latency):
    - ADDR_SW -> {16'b0, sw_db}
    - ADDR_BTN -> {28'b0, btn_db}
    - ADDR_EVT -> {28'b0, evt}
    - any other address -> 32'b0
  - With RE=0, dataread holds its last value.
  - A read of ADDR_EVT returns the flag value before any same-cycle set/clear.
  - Reads never modify state.
- Writes:
  - WE to ADDR_SW or ADDR_BTN is ignored.
  - WE to any unmapped address is ignored.
  - RE and WE in the same cycle are both honoured independently.
- event_pending = |evt, registered; it updates one cycle after the flags.
- Addresses are compared on all 32 bits (no aliasing).

Decomposition:
- Shared package:
  - Address constants ADDR_SW/ADDR_BTN/ADDR_EVT, alongside the display address 32'h0148 kept in the same package.
  - Widths SW_W=16 and BTN_W=4.
- One natural sub-module: debounce_bit.
  - Contents: one-bit 2-flop synchronizer, counter and debounced output.
  - Parameterized by DEBOUNCE_CYCLES.
  - Instantiated 20 times via generate.
  - Also provides a registered rise pulse output for event detection.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset, then RE at ADDR_SW, ADDR_BTN, ADDR_EVT and 32'h0000 -> dataread=0 each, event_pending=0.
- sw=16'hA5C3 held stable -> after 6 cycles, RE at 32'h0150 gives dataread=32'h0000A5C3 one cycle later; a read at cycle 5 still returns 0.
- btn[2] pulsed high for 3 cycles then low -> btn_db and evt stay 0. btn[2] held for 10 cycles -> read ADDR_BTN=32'h4, ADDR_EVT=32'h4, event_pending=1.
- With evt=4'b0110, WE at 32'h0158 with datain=32'h2 -> evt=4'b0100. Then a write of 32'hFFFFFFFF -> evt=0 and event_pending=0 one cycle later.
- Debounced rising edge on btn[0] in the same cycle as a clear write of datain=32'h1 -> evt[0]=1 afterwards.
- rst_n asserted low asynchronously between edges mid-debounce with sw held -> dataread and all flags 0 immediately. After release, a full 2+4-cycle debounce is required before ADDR_SW reflects sw.
